// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding request, response LATENCY+1 edges after acceptance.
// Backpressure: req_ready only in IDLE; the response holds in RESP until resp_ready.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, commit, q_err;
    logic        q_we;
    logic [31:0] q_addr, q_wdata;
    logic [3:0]  q_be;
    logic [AW-1:0] q_idx;
    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign q_idx      = q_addr[AW+1:2];
    assign q_err      = (q_addr[1:0] != 2'b00) || (q_addr >= 32'(4 * DEPTH_WORDS));

    // WAIT always lasts LATENCY+1 cycles so the response lands LATENCY+1 edges after acceptance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            q_we    <= 1'b0;
            q_addr  <= 32'd0;
            q_wdata <= 32'd0;
            q_be    <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                q_we    <= req_we;
                q_addr  <= req_addr;
                q_wdata <= req_wdata;
                q_be    <= req_be;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_err   <= q_err;
            resp_rdata <= (!q_we && !q_err) ? mem[q_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < DEPTH_WORDS; w++) mem[w] <= 32'd0;
        end else if (commit && q_we && !q_err) begin
            for (int i = 0; i < 4; i++) begin
                if (q_be[i]) mem[q_idx][8*i +: 8] <= q_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed and random transactions against a word-array reference model.
module tb_dm_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 3072;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        z_valid, z_ready, z_resp_valid, z_err;
    logic [31:0] z_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_valid), .req_ready(z_ready), .req_we(1'b0),
        .req_addr(32'h0000_0010), .req_wdata(32'h0), .req_be(4'h0),
        .resp_valid(z_resp_valid), .resp_ready(1'b1),
        .resp_rdata(z_rdata), .resp_err(z_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < DEPTH; w++) model[w] = 32'd0;
    endtask

    // Reference: apply the request to the model, return the response it must produce.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] rd, output logic err);
        err = (addr % 4 != 0) || (addr >= 4 * DEPTH);
        rd  = 32'd0;
        if (!err && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[addr / 4][8*b +: 8] = wdata[8*b +: 8];
        end else if (!err) begin
            rd = model[addr / 4];
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        resp_ready = 1'b0;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        model_apply(we, addr, wdata, be, exp_rd, exp_err);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency_edges", 32'(n), 32'(LAT + 1));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rd = resp_rdata;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("consumed_valid", 32'(resp_valid), 32'd0);
        chk("consumed_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd, addr;
        logic        we;
        int          kind;

        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        resp_ready = 1'b0; z_valid = 1'b0;
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic store/load, partial byte enables, latency.
        xact(1'b1, 32'h10, 32'h1234_5678, 4'hF, 0, rd);
        chk("store_rdata_zero", rd, 32'd0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("load_0x10", rd, 32'h1234_5678);
        xact(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd);
        xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1, rd);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        chk("byte_merge", rd, 32'h11BB_33DD);
        xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, rd);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        chk("be_zero_unchanged", rd, 32'h11BB_33DD);

        // Error cases; the misaligned store must not touch word 0x10.
        xact(1'b0, 32'h3000, 32'h0, 4'h0, 0, rd);
        xact(1'b0, 32'h6, 32'h0, 4'h0, 0, rd);
        xact(1'b1, 32'h12, 32'hDEAD_BEEF, 4'hF, 0, rd);
        xact(1'b1, 32'h2FFC, 32'hCAFE_F00D, 4'hF, 0, rd);
        xact(1'b0, 32'h2FFC, 32'h0, 4'h0, 0, rd);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("err_no_write", rd, 32'h1234_5678);

        // Stall the response for 5 cycles.
        xact(1'b0, 32'h10, 32'h0, 4'h0, 5, rd);

        // Randomized mix.
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if (kind == 8) addr = addr | 32'($urandom_range(1, 3));
            if (kind == 9) addr = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            we = 1'($urandom_range(0, 1));
            xact(we, addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), rd);
        end

        // Reset mid-WAIT of a store: outputs clear at once, store dropped, memory cleared.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_wait_busy", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_rdata", resp_rdata, 32'd0);
        chk("midrst_err", 32'(resp_err), 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        xact(1'b0, 32'h40, 32'h0, 4'h0, 0, rd);
        chk("aborted_store", rd, 32'd0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("reset_cleared", rd, 32'd0);

        // LATENCY=0 instance: request held, response always consumed -> period of 3 edges.
        @(negedge clk);
        z_valid = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            chk("lat0_resp_valid", 32'(z_resp_valid), 32'(e % 3 == 2));
            chk("lat0_req_ready", 32'(z_ready), 32'(e % 3 == 0));
            if (e % 3 == 2) chk("lat0_err", 32'(z_err), 32'd0);
        end
        z_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
